// File: rtl/gate_exhaustive_checker.sv
// gate_exhaustive_checker: drives every input vector of a combinational gate in ascending order,
// holds each for SETTLE cycles, then checks the gate output against a reference function.
module gate_exhaustive_checker #(
    parameter int N_IN   = 2,
    parameter int SETTLE = 2,
    parameter int FUNC   = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic [N_IN-1:0] vec_out,
    input  logic            dut_out,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic [N_IN-1:0] fail_vec,
    output logic            fail_valid
);
    localparam int CW = SETTLE > 1 ? $clog2(SETTLE) : 1;
    typedef enum logic [1:0] {IDLE, WAIT, CHECK, DONE} state_t;
    state_t        state;
    logic [CW-1:0] cnt;
    logic          expected;
    logic          mismatch;
    // unknown FUNC codes fall through to NOR
    always_comb begin
        expected = FUNC == 1 ? ~&vec_out :
                   FUNC == 2 ?  &vec_out :
                   FUNC == 3 ?  |vec_out :
                   FUNC == 4 ?  ^vec_out : ~|vec_out;
        mismatch = dut_out != expected;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            vec_out    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_vec   <= '0;
            fail_valid <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    vec_out    <= '0;
                    cnt        <= '0;
                    err_count  <= '0;
                    fail_vec   <= '0;
                    fail_valid <= 1'b0;
                    pass       <= 1'b0;
                    busy       <= 1'b1;
                    state      <= WAIT;
                end
                WAIT: begin
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(SETTLE - 1)) state <= CHECK;
                end
                CHECK: begin
                    if (mismatch) begin
                        err_count <= err_count + (N_IN+1)'(1);
                        if (!fail_valid) begin
                            fail_vec   <= vec_out;
                            fail_valid <= 1'b1;
                        end
                    end
                    if (vec_out == '1) begin
                        busy  <= 1'b0;
                        state <= DONE;
                    end else begin
                        vec_out <= vec_out + N_IN'(1);
                        cnt     <= '0;
                        state   <= WAIT;
                    end
                end
                DONE: begin
                    done    <= 1'b1;
                    pass    <= err_count == '0;
                    vec_out <= '0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
